// File: rtl/rb_port_arbiter_if.sv
// Two-requester register-bank port bundle: requester side plus the 32x8 bank port.
// Latency: none (wires only).
// Backpressure: requesters wait on gnt0/gnt1; the bank itself never stalls.
interface rb_port_arbiter_if;
   logic       req0;
   logic       lock0;
   logic       rw0;
   logic [4:0] addr0;
   logic [7:0] wd0;
   logic       gnt0;
   logic       rv0;

   logic       req1;
   logic       lock1;
   logic       rw1;
   logic [4:0] addr1;
   logic [7:0] wd1;
   logic       gnt1;
   logic       rv1;

   logic [7:0] rdata;
   logic       RB_RW;
   logic [4:0] RB_A;
   logic [7:0] RB_D;
   logic [7:0] RB_Q;

   // Arbiter side
   modport slave (
      input  req0, lock0, rw0, addr0, wd0,
      input  req1, lock1, rw1, addr1, wd1,
      input  RB_Q,
      output gnt0, rv0, gnt1, rv1,
      output rdata, RB_RW, RB_A, RB_D
   );

   // Requesters and bank side
   modport master (
      output req0, lock0, rw0, addr0, wd0,
      output req1, lock1, rw1, addr1, wd1,
      output RB_Q,
      input  gnt0, rv0, gnt1, rv1,
      input  rdata, RB_RW, RB_A, RB_D
   );
endinterface

// File: rtl/rb_port_arbiter.sv
// Round-robin owner of the single 32x8 register-bank port, with lock for atomic bursts.
// Latency: gnt 1 cycle after req from idle, no bubble on handover; rv 1 cycle after a read.
// Backpressure: a requester waits with req held until gnt; RB_ARB_BURST_LIMIT_EN caps locked tenures at MAX_BURST when contended.
module rb_port_arbiter #(
   parameter int MAX_BURST = 8
) (
   input logic             clk,
   input logic             rst,
   rb_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t state;
   logic   gnt0;
   logic   gnt1;
   logic   rv0;
   logic   rv1;
   logic   ptr;      // 0: requester 0 wins the next tie

   logic   acc0;
   logic   acc1;
   logic   limit0;
   logic   limit1;
   logic   rel0;
   logic   rel1;
   logic   arb;

   // An access happens only when the owner is actually requesting.
   assign acc0 = gnt0 & bus.req0;
   assign acc1 = gnt1 & bus.req1;

`ifdef RB_ARB_BURST_LIMIT_EN
   logic [4:0] burst_cnt;   // accesses already done in this tenure
   logic       at_limit;

   assign at_limit = ({1'b0, burst_cnt} + 6'd1) >= 6'(MAX_BURST);
   assign limit0   = at_limit & bus.req1;
   assign limit1   = at_limit & bus.req0;

   // Count accesses per tenure; restart on every grant decision, saturate at the cap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         burst_cnt <= 5'd0;
      else if (arb)
         burst_cnt <= 5'd0;
      else if ((acc0 | acc1) && (burst_cnt < 5'(MAX_BURST)))
         burst_cnt <= burst_cnt + 5'd1;
   end
`else
   localparam int unused_max_burst = MAX_BURST;
   assign limit0 = 1'b0;
   assign limit1 = 1'b0;
`endif

   // Owner lets go when it stops requesting or finishes an unlocked (or capped) access.
   assign rel0 = gnt0 & (~bus.req0 | ~bus.lock0 | limit0);
   assign rel1 = gnt1 & (~bus.req1 | ~bus.lock1 | limit1);
   assign arb  = (state == IDLE) | rel0 | rel1;

   // Owner FSM: registered grants, read-valid pulses and round-robin pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         rv0   <= 1'b0;
         rv1   <= 1'b0;
         ptr   <= 1'b0;
      end else begin
         rv0 <= acc0 & bus.rw0;
         rv1 <= acc1 & bus.rw1;
         if (arb) begin
            if (bus.req0 && (!bus.req1 || !ptr)) begin
               state <= OWN0;
               gnt0  <= 1'b1;
               gnt1  <= 1'b0;
               ptr   <= 1'b1;
            end else if (bus.req1) begin
               state <= OWN1;
               gnt0  <= 1'b0;
               gnt1  <= 1'b1;
               ptr   <= 1'b0;
            end else begin
               state <= IDLE;
               gnt0  <= 1'b0;
               gnt1  <= 1'b0;
            end
         end
      end
   end

   // Bank port follows the current owner's request; idle read of address 0 otherwise.
   always_comb begin
      bus.RB_RW = 1'b1;
      bus.RB_A  = 5'd0;
      bus.RB_D  = 8'd0;
      if (acc0) begin
         bus.RB_RW = bus.rw0;
         bus.RB_A  = bus.addr0;
         bus.RB_D  = bus.wd0;
      end else if (acc1) begin
         bus.RB_RW = bus.rw1;
         bus.RB_A  = bus.addr1;
         bus.RB_D  = bus.wd1;
      end
   end

   assign bus.gnt0  = gnt0;
   assign bus.gnt1  = gnt1;
   assign bus.rv0   = rv0;
   assign bus.rv1   = rv1;
   assign bus.rdata = bus.RB_Q;

endmodule

// File: doc/rb_port_arbiter.md
Name: rb_port_arbiter

Overview:
- Shares the single 32x8 register-bank port (RW/A/D/Q) between two requesters, e.g. the serial frame transmitter and a host loader/checker.
- Owns the bank port outright and grants it one requester at a time.
- Round-robin priority; optional lock for atomic bursts such as an 18-read column scan.
- Sits between the requesters and the bank; the bank returns read data on Q one cycle after the address.

Parameters:
- MAX_BURST, 8, maximum accesses per locked tenure, legal range 1..31. Used only with RB_ARB_BURST_LIMIT_EN.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
req0  in  1  requester 0 wants the port
lock0  in  1  requester 0 keeps the grant after its current access
rw0  in  1  requester 0 access type: 1 = read, 0 = write
addr0  in  5  requester 0 bank address
wd0  in  8  requester 0 write data
gnt0  out  1  requester 0 owns the port this cycle
rv0  out  1  read data valid on rdata for requester 0
req1, lock1, rw1, addr1, wd1, gnt1, rv1  same as the requester-0 ports, for requester 1
rdata  out  8  direct pass-through of RB_Q, shared by both requesters
RB_RW  out  1  bank read/write: 1 = read, 0 = write
RB_A  out  5  bank address
RB_D  out  8  bank write data
RB_Q  in  8  bank read data, valid one cycle after the address

Behaviour:
- Reset (rst=0, asynchronous):
  - gnt0 = gnt1 = 0, rv0 = rv1 = 0, owner = none.
  - Round-robin pointer = 0, so requester 0 wins the first tie.
  - Burst counter = 0.
  - Port is idle: RB_RW=1, RB_A=0, RB_D=0.
- Reset mid-operation: the in-flight access is abandoned and no rv pulse follows.
- States:
  - IDLE: no owner.
  - OWN0: gnt0=1.
  - OWN1: gnt1=1.
  - gnt0/gnt1 are registered and mutually exclusive at all times.
- Access cycle: state OWNi with reqi=1.
  - RB_RW/RB_A/RB_D are driven combinationally from rwi/addri/wdi.
  - In every other cycle the port is idle (RB_RW=1, A=0, D=0). A write can never occur without a grant.
- Read return: rvi=1 in the cycle after a read access by i. rdata=RB_Q is valid in that cycle. Writes produce no rv.
- Release condition while in OWNi, evaluated each cycle; the grant is released if either holds:
  - (a) reqi=0 (no access takes place), or
  - (b) an access cycle with locki=0 (single access; the access itself completes).
- Arbitration happens in IDLE or in a release cycle, with the next state registered:
  - Only one req high: that requester is granted.
  - Both high: the requester not served last is granted, then the pointer toggles.
  - Neither high: go to IDLE.
  - The releasing requester's own req counts, so a single active requester is regranted back-to-back.
- Latency:
  - From IDLE: gnt rises 1 cycle after req.
  - On handover: new gnt rises the cycle after the release cycle, with no bubble. Back-to-back accesses by different requesters are possible.
- Lock:
  - While locki=1 and reqi=1, the grant is held indefinitely. One access per cycle; the other requester waits.
  - Lock is ignored in IDLE; it only extends an existing grant.
- Requester changes rw/addr/wd while unlocked: each access cycle samples its own current values; nothing is latched by the arbiter.
- rv ordering: an rv pulse from the previous owner may coincide with the new owner's first access cycle. rv0 and rv1 can never both be 1.

Optional Feature:
- Macro: RB_ARB_BURST_LIMIT_EN.
- When defined:
  - A 5-bit counter counts access cycles in the current tenure and clears on each new grant.
  - When the count reaches MAX_BURST and the other requester's req=1, the grant is force-released after that access, as if lock were 0.
  - If the other requester is not requesting, the lock is honoured and the counter saturates.
- When undefined: no counter exists and lock is unbounded.

Test Plan:
- Reset then req0=1, rw0=1, addr0=5, lock0=0 → gnt0=1 in cycle 1, RB_A=5, RB_RW=1 in that cycle, rv0=1 with rdata=RB_Q in cycle 2; gnt0 then re-asserts the following cycle while req0 is held.
- req0 and req1 rise in the same cycle after reset, both single reads → grant order 0,1,0,1 with no idle cycle between grants, and gnt0&gnt1 never 1.
- Requester 1 write: rw1=0, addr1=31, wd1=8'hA5 → exactly one cycle with RB_RW=0, RB_A=31, RB_D=A5, and no rv1.
- req0 with lock0=1 for 18 reads (addr 0..17) while req1=1 → 18 contiguous grant0 cycles, gnt1 rises the cycle after lock0 falls, rv0 pulses 18 times.
- Assert rst=0 mid-burst at access 7 → all outputs return to reset values immediately (asynchronously), no rv pulse next cycle, and requester 0 wins the next tie.
- With RB_ARB_BURST_LIMIT_EN and MAX_BURST=8: locked req0 plus req1 → requester 0 gets exactly 8 accesses, then requester 1 is granted. Same case with req1=0 → requester 0 is never preempted.
